rand_coord_gen: RTL and testbench
=================================

Name: rand_coord_gen

Overview:
- Parametrised successor to the 4-bit x/y LFSR pair that feeds game-object placement on the VGA grid.
- Two free-running Fibonacci LFSRs of configurable width and tap mask.
- Request/valid handshake returns one (x, y) grid coordinate per request.
- Uses rejection sampling, so the distribution is uniform across X_RANGE × Y_RANGE; a bounded fallback guarantees a result. Runtime reseeding is supported.

Parameters:
- WIDTH, 8: LFSR register width, min 4.
- TAPS, 8'hB8: feedback tap mask; feedback = XOR-reduce(reg & TAPS). The default gives period 255.
- X_RANGE, 10: x output range 0..X_RANGE-1. Requires 2 ≤ X_RANGE ≤ 2^WIDTH.
- Y_RANGE, 10: y output range 0..Y_RANGE-1, same constraint.
- SEED_X, 8'h03: reset/substitute seed for the x LFSR, nonzero.
- SEED_Y, 8'h0B: reset/substitute seed for the y LFSR, nonzero.
- MAX_TRIES, 16: candidates evaluated before fallback, ≥ 1.

Ports:
- clk, in, 1: clock.
- reset, in, 1: synchronous, active-high reset.
- req, in, 1: request one coordinate; sampled only in IDLE.
- seed_load, in, 1: load seed_x/seed_y into the LFSRs this edge.
- seed_x, in, WIDTH: x seed.
- seed_y, in, WIDTH: y seed.
- busy, out, 1: high while in SEARCH.
- valid, out, 1: one-cycle pulse; x_out/y_out are new.
- x_out, out, XW = clog2(X_RANGE): coordinate x, held until the next valid.
- y_out, out, YW = clog2(Y_RANGE): coordinate y, held until the next valid.
- fallback, out, 1: qualifies valid; the result came from the fallback path.

Behaviour:
- One clock (clk); reset is synchronous and active-high.
- Reset state:
  - x_reg = SEED_X, y_reg = SEED_Y.
  - State IDLE, try counter 0.
  - busy = 0, valid = 0, fallback = 0, x_out = 0, y_out = 0.
- LFSR step, every cycle, in all states: reg <= {reg[WIDTH-2:0], ^(reg & TAPS)}.
- seed_load priority:
  - seed_load overrides the step that edge: reg <= seed.
  - A seed of 0 is replaced by SEED_X/SEED_Y, so the all-zero lock-up state is unreachable.
  - seed_load is legal in any state. In SEARCH, evaluation continues on the new values and the try counter is not reset.
- Candidates:
  - cand_x = x_reg[XW-1:0], cand_y = y_reg[YW-1:0], taken combinationally from the current registers.
  - A candidate is accepted iff cand_x < X_RANGE and cand_y < Y_RANGE, plus the exclusion rule when enabled. Both axes are rejected together.
- FSM:
  - IDLE:
    - req=1 → SEARCH, try counter <= 0.
    - A req in the same cycle as a valid pulse is accepted.
  - SEARCH, evaluated once per cycle:
    - Accept → latch x_out/y_out, valid=1 and fallback=0 next cycle, → IDLE.
    - Reject with tries < MAX_TRIES-1 → tries+1, stay in SEARCH.
    - Reject with tries == MAX_TRIES-1 → fallback:
      - Per axis: out = cand ≥ RANGE ? cand − RANGE : cand. This is always in range because RANGE > 2^(XW-1).
      - fallback=1 with valid; → IDLE.
      - Exclusion is ignored on the fallback path.
- Latency:
  - req at edge t → first evaluation in cycle t+1.
  - valid at t+2 best case; at most t+1+MAX_TRIES.
- Handshake rules:
  - req while busy is ignored (not queued).
  - valid and fallback are one-cycle pulses; fallback is 0 whenever valid=0.
- seed_load and req in the same cycle: the first evaluation sees exactly the loaded seed.
- Power-of-two ranges are never rejected.
- reset mid-SEARCH: abort, return to the reset state, no valid pulse.

Optional Feature:
- Macro: RAND_COORD_EXCLUDE_EN.
- When defined:
  - Adds inputs excl_x[XW] and excl_y[YW].
  - A candidate with (cand_x, cand_y) == (excl_x, excl_y) is rejected and counts as a try. Use case: avoid placing food on the snake head.
- When undefined: those ports are absent and no exclusion is applied.

Test Plan:
- Reset: hold reset=1 for 2 cycles, then release → busy=0, valid=0, x_out=0, y_out=0. x_reg sequence has period 255 and never reaches 0.
- Basic request: seed_load with seed_x=8'h03, seed_y=8'h05, req in the same cycle → valid 2 edges later with x_out=3, y_out=5, fallback=0.
- Fallback: MAX_TRIES=1, seed_load with seed_x=8'h0C, seed_y=8'h05, req in the same cycle → valid 2 edges later with x_out=2, y_out=5, fallback=1.
- Zero seed: seed_load with seed_x=0, seed_y=0 → registers hold 8'h03/8'h0B; the sequence keeps stepping.
- Statistics: 2000 back-to-back requests → every x_out and y_out < 10; each value 0..9 appears on each axis; each latency ≤ MAX_TRIES+1; req pulses while busy produce no extra valid.
- Exclusion (RAND_COORD_EXCLUDE_EN): excl=(3,5), seed (03,05), req → the (3,5) candidate is rejected and the returned coordinate ≠ (3,5), or fallback=1. Also: reset asserted mid-SEARCH → no valid pulse, and the state is back to reset values the next cycle.

Source files
------------

// File: rtl/rand_coord_gen.sv
// Uniform (x, y) grid coordinate generator: two free-running Fibonacci LFSRs with rejection sampling.
// Optional macro RAND_COORD_EXCLUDE_EN adds excl_x/excl_y to reject one forbidden coordinate.
module rand_coord_gen #(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] TAPS      = 8'hB8,
   parameter int               X_RANGE   = 10,
   parameter int               Y_RANGE   = 10,
   parameter logic [WIDTH-1:0] SEED_X    = 8'h03,
   parameter logic [WIDTH-1:0] SEED_Y    = 8'h0B,
   parameter int               MAX_TRIES = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         req,
   input  logic                         seed_load,
   input  logic [WIDTH-1:0]             seed_x,
   input  logic [WIDTH-1:0]             seed_y,
`ifdef RAND_COORD_EXCLUDE_EN
   input  logic [$clog2(X_RANGE)-1:0]   excl_x,
   input  logic [$clog2(Y_RANGE)-1:0]   excl_y,
`endif
   output logic                         busy,
   output logic                         valid,
   output logic [$clog2(X_RANGE)-1:0]   x_out,
   output logic [$clog2(Y_RANGE)-1:0]   y_out,
   output logic                         fallback
);

   localparam int XW = $clog2(X_RANGE);
   localparam int YW = $clog2(Y_RANGE);
   localparam int TW = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

   localparam logic [XW:0]   X_LIM    = (XW+1)'(X_RANGE);
   localparam logic [YW:0]   Y_LIM    = (YW+1)'(Y_RANGE);
   localparam logic [XW-1:0] X_SUB    = X_LIM[XW-1:0];
   localparam logic [YW-1:0] Y_SUB    = Y_LIM[YW-1:0];
   localparam logic [TW-1:0] LAST_TRY = TW'(MAX_TRIES - 1);

   typedef enum logic {
      IDLE,
      SEARCH
   } state_t;

   state_t          state_q;
   state_t          state_d;
   logic [TW-1:0]   tries_q;
   logic [TW-1:0]   tries_d;
   logic [WIDTH-1:0] x_reg;
   logic [WIDTH-1:0] y_reg;
   logic [WIDTH-1:0] x_load;
   logic [WIDTH-1:0] y_load;
   logic [XW-1:0]   cand_x;
   logic [YW-1:0]   cand_y;
   logic            in_x;
   logic            in_y;
   logic            excl_hit;
   logic            accept;
   logic            valid_d;
   logic            fallback_d;
   logic [XW-1:0]   x_out_d;
   logic [YW-1:0]   y_out_d;

   // A zero seed would lock the LFSR, so it is swapped for the reset seed.
   assign x_load = (seed_x == '0) ? SEED_X : seed_x;
   assign y_load = (seed_y == '0) ? SEED_Y : seed_y;

   always_ff @(posedge clk) begin
      if (reset) begin
         x_reg <= SEED_X;
         y_reg <= SEED_Y;
      end else if (seed_load) begin
         x_reg <= x_load;
         y_reg <= y_load;
      end else begin
         x_reg <= {x_reg[WIDTH-2:0], ^(x_reg & TAPS)};
         y_reg <= {y_reg[WIDTH-2:0], ^(y_reg & TAPS)};
      end
   end

   assign cand_x = x_reg[XW-1:0];
   assign cand_y = y_reg[YW-1:0];
   assign in_x   = ({1'b0, cand_x} < X_LIM);
   assign in_y   = ({1'b0, cand_y} < Y_LIM);

`ifdef RAND_COORD_EXCLUDE_EN
   assign excl_hit = (cand_x == excl_x) && (cand_y == excl_y);
`else
   assign excl_hit = 1'b0;
`endif

   assign accept = in_x && in_y && !excl_hit;
   assign busy   = (state_q == SEARCH);

   // Fallback folds an out-of-range candidate down by one range; it always lands in range
   // because each range exceeds half of its power-of-two candidate space.
   always_comb begin
      state_d    = state_q;
      tries_d    = tries_q;
      valid_d    = 1'b0;
      fallback_d = 1'b0;
      x_out_d    = x_out;
      y_out_d    = y_out;
      case (state_q)
         IDLE: begin
            if (req) begin
               state_d = SEARCH;
               tries_d = '0;
            end
         end
         SEARCH: begin
            if (accept) begin
               x_out_d = cand_x;
               y_out_d = cand_y;
               valid_d = 1'b1;
               state_d = IDLE;
            end else if (tries_q == LAST_TRY) begin
               x_out_d    = in_x ? cand_x : (cand_x - X_SUB);
               y_out_d    = in_y ? cand_y : (cand_y - Y_SUB);
               valid_d    = 1'b1;
               fallback_d = 1'b1;
               state_d    = IDLE;
            end else begin
               tries_d = tries_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         tries_q  <= '0;
         valid    <= 1'b0;
         fallback <= 1'b0;
         x_out    <= '0;
         y_out    <= '0;
      end else begin
         state_q  <= state_d;
         tries_q  <= tries_d;
         valid    <= valid_d;
         fallback <= fallback_d;
         x_out    <= x_out_d;
         y_out    <= y_out_d;
      end
   end

endmodule

// File: tb/tb_rand_coord_gen.sv
// Directed self-checking bench for rand_coord_gen (default build and RAND_COORD_EXCLUDE_EN build).
module tb_rand_coord_gen;

   localparam int MAX_T = 16;

   logic       clk;
   logic       reset;
   logic       req;
   logic       seed_load;
   logic [7:0] seed_x;
   logic [7:0] seed_y;
   logic       busy;
   logic       valid;
   logic [3:0] x_out;
   logic [3:0] y_out;
   logic       fallback;
`ifdef RAND_COORD_EXCLUDE_EN
   logic [3:0] excl_x;
   logic [3:0] excl_y;
`endif

   logic       fb_req;
   logic       fb_seed_load;
   logic       fb_busy;
   logic       fb_valid;
   logic [3:0] fb_x_out;
   logic [3:0] fb_y_out;
   logic       fb_fallback;

   int checks;
   int errors;

   rand_coord_gen #(.MAX_TRIES(MAX_T)) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .seed_load (seed_load),
      .seed_x    (seed_x),
      .seed_y    (seed_y),
`ifdef RAND_COORD_EXCLUDE_EN
      .excl_x    (excl_x),
      .excl_y    (excl_y),
`endif
      .busy      (busy),
      .valid     (valid),
      .x_out     (x_out),
      .y_out     (y_out),
      .fallback  (fallback)
   );

   rand_coord_gen #(.MAX_TRIES(1)) dut_fb (
      .clk       (clk),
      .reset     (reset),
      .req       (fb_req),
      .seed_load (fb_seed_load),
      .seed_x    (seed_x),
      .seed_y    (seed_y),
`ifdef RAND_COORD_EXCLUDE_EN
      .excl_x    (4'd15),
      .excl_y    (4'd15),
`endif
      .busy      (fb_busy),
      .valid     (fb_valid),
      .x_out     (fb_x_out),
      .y_out     (fb_y_out),
      .fallback  (fb_fallback)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] lfsr_step(input logic [7:0] r);
      return {r[6:0], ^(r & 8'hB8)};
   endfunction

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (dut.x_reg !== 8'h03 || dut.y_reg !== 8'h0B) begin
         errors++;
         $display("[TB] FAIL reset_regs: got %h/%h expected 03/0b", dut.x_reg, dut.y_reg);
      end
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || valid !== 1'b0 || fallback !== 1'b0 || x_out !== 4'd0 || y_out !== 4'd0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got busy=%b valid=%b fb=%b x=%0d y=%0d expected all 0",
                  busy, valid, fallback, x_out, y_out);
      end
      checks++;
      if (dut.x_reg !== 8'h06 || dut.y_reg !== 8'h17) begin
         errors++;
         $display("[TB] FAIL reset_first_step: got %h/%h expected 06/17", dut.x_reg, dut.y_reg);
      end
   endtask

   task automatic test_basic();
      @(negedge clk);
      seed_x = 8'h03; seed_y = 8'h05; seed_load = 1'b1; req = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b1 || valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL basic_busy: got busy=%b valid=%b expected 1/0", busy, valid);
      end
      @(negedge clk);
      seed_load = 1'b0; req = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (valid !== 1'b1 || x_out !== 4'd3 || y_out !== 4'd5 || fallback !== 1'b0) begin
         errors++;
         $display("[TB] FAIL basic_result: got v=%b x=%0d y=%0d fb=%b expected 1/3/5/0",
                  valid, x_out, y_out, fallback);
      end
      @(posedge clk);
      #1;
      checks++;
      if (valid !== 1'b0 || busy !== 1'b0 || x_out !== 4'd3 || y_out !== 4'd5) begin
         errors++;
         $display("[TB] FAIL basic_hold: got v=%b busy=%b x=%0d y=%0d expected 0/0/3/5",
                  valid, busy, x_out, y_out);
      end
   endtask

   // Seed (0C,05) rejects twice before (2,5); a req on the valid cycle then yields (9,6).
   task automatic test_back_to_back();
      @(negedge clk);
      seed_x = 8'h0C; seed_y = 8'h05; seed_load = 1'b1; req = 1'b1;
      @(negedge clk);
      seed_load = 1'b0; req = 1'b0;
      repeat (2) begin
         @(posedge clk);
         #1;
         checks++;
         if (valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_reject: got v=%b busy=%b expected 0/1", valid, busy);
         end
      end
      @(posedge clk);
      #1;
      checks++;
      if (valid !== 1'b1 || x_out !== 4'd2 || y_out !== 4'd5 || fallback !== 1'b0) begin
         errors++;
         $display("[TB] FAIL b2b_first: got v=%b x=%0d y=%0d fb=%b expected 1/2/5/0",
                  valid, x_out, y_out, fallback);
      end
      @(negedge clk);
      req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      checks++;
      if (busy !== 1'b1 || valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL b2b_req_on_valid: got busy=%b v=%b expected 1/0", busy, valid);
      end
      @(posedge clk);
      #1;
      checks++;
      if (valid !== 1'b1 || x_out !== 4'd9 || y_out !== 4'd6 || fallback !== 1'b0) begin
         errors++;
         $display("[TB] FAIL b2b_second: got v=%b x=%0d y=%0d fb=%b expected 1/9/6/0",
                  valid, x_out, y_out, fallback);
      end
   endtask

   task automatic test_fallback();
      @(negedge clk);
      seed_x = 8'h0C; seed_y = 8'h05; fb_seed_load = 1'b1; fb_req = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (fb_busy !== 1'b1 || fb_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL fallback_busy: got busy=%b v=%b expected 1/0", fb_busy, fb_valid);
      end
      @(negedge clk);
      fb_seed_load = 1'b0; fb_req = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (fb_valid !== 1'b1 || fb_x_out !== 4'd2 || fb_y_out !== 4'd5 || fb_fallback !== 1'b1) begin
         errors++;
         $display("[TB] FAIL fallback_result: got v=%b x=%0d y=%0d fb=%b expected 1/2/5/1",
                  fb_valid, fb_x_out, fb_y_out, fb_fallback);
      end
      @(posedge clk);
      #1;
      checks++;
      if (fb_valid !== 1'b0 || fb_fallback !== 1'b0) begin
         errors++;
         $display("[TB] FAIL fallback_pulse: got v=%b fb=%b expected 0/0", fb_valid, fb_fallback);
      end
   endtask

   task automatic test_zero_seed();
      logic [7:0] mx;
      logic [7:0] my;
      int         period;
      int         zero_seen;
      int         model_err;
      @(negedge clk);
      seed_x = 8'h00; seed_y = 8'h00; seed_load = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (dut.x_reg !== 8'h03 || dut.y_reg !== 8'h0B) begin
         errors++;
         $display("[TB] FAIL zero_seed_load: got %h/%h expected 03/0b", dut.x_reg, dut.y_reg);
      end
      @(negedge clk);
      seed_load = 1'b0;
      mx = 8'h03; my = 8'h0B;
      period = 0; zero_seen = 0; model_err = 0;
      for (int n = 1; n <= 300; n++) begin
         @(posedge clk);
         #1;
         mx = lfsr_step(mx);
         my = lfsr_step(my);
         if (dut.x_reg == 8'h00 || dut.y_reg == 8'h00) zero_seen++;
         if (dut.x_reg !== mx || dut.y_reg !== my) model_err++;
         if (dut.x_reg == 8'h03) begin
            period = n;
            break;
         end
      end
      checks++;
      if (period !== 255) begin
         errors++;
         $display("[TB] FAIL lfsr_period: got %0d expected 255", period);
      end
      checks++;
      if (zero_seen !== 0 || model_err !== 0) begin
         errors++;
         $display("[TB] FAIL lfsr_sequence: got zero=%0d step_err=%0d expected 0/0", zero_seen, model_err);
      end
   endtask

`ifdef RAND_COORD_EXCLUDE_EN
   task automatic test_exclusion();
      int k;
      bit got;
      excl_x = 4'd3; excl_y = 4'd5;
      @(negedge clk);
      seed_x = 8'h03; seed_y = 8'h05; seed_load = 1'b1; req = 1'b1;
      @(negedge clk);
      seed_load = 1'b0; req = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL excl_first_reject: got v=%b expected 0", valid);
      end
      got = 0; k = 0;
      while (!got && k < MAX_T + 2) begin
         @(posedge clk);
         #1;
         k++;
         if (valid) got = 1;
      end
      checks++;
      if (!got) begin
         errors++;
         $display("[TB] FAIL excl_timeout: got no valid expected valid");
      end else if (x_out == 4'd3 && y_out == 4'd5 && fallback == 1'b0) begin
         errors++;
         $display("[TB] FAIL excl_result: got (3,5) fb=0 expected other coordinate or fb=1");
      end
      excl_x = 4'd15; excl_y = 4'd15;
   endtask
`endif

   task automatic test_statistics();
      int hx[10];
      int hy[10];
      int k;
      int gap;
      bit got;
      for (int v = 0; v < 10; v++) begin
         hx[v] = 0;
         hy[v] = 0;
      end
      for (int i = 0; i < 2000; i++) begin
         gap = $urandom_range(0, 3);
         repeat (gap) @(negedge clk);
         @(negedge clk);
         req = 1'b1;
         got = 0; k = 0;
         while (!got && k < MAX_T + 4) begin
            @(posedge clk);
            #1;
            k++;
            if (valid) begin
               got = 1;
               req = 1'b0;
            end else begin
               req = (k % 2 == 1);
            end
         end
         req = 1'b0;
         checks++;
         if (!got) begin
            errors++;
            $display("[TB] FAIL stats_timeout: req %0d got no valid expected valid", i);
         end else begin
            checks++;
            if (k < 2 || k > MAX_T + 1) begin
               errors++;
               $display("[TB] FAIL stats_latency: req %0d got %0d expected 2..%0d", i, k, MAX_T + 1);
            end
            checks++;
            if (x_out >= 4'd10 || y_out >= 4'd10) begin
               errors++;
               $display("[TB] FAIL stats_range: req %0d got x=%0d y=%0d expected <10", i, x_out, y_out);
            end else begin
               hx[x_out]++;
               hy[y_out]++;
            end
         end
         @(posedge clk);
         #1;
         checks++;
         if (valid !== 1'b0 || busy !== 1'b0 || fallback !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stats_extra_valid: req %0d got v=%b busy=%b fb=%b expected 0/0/0",
                     i, valid, busy, fallback);
         end
      end
      for (int v = 0; v < 10; v++) begin
         checks++;
         if (hx[v] == 0 || hy[v] == 0) begin
            errors++;
            $display("[TB] FAIL stats_coverage: value %0d got x=%0d y=%0d hits expected >0", v, hx[v], hy[v]);
         end
      end
   endtask

   task automatic test_reset_mid_search();
      @(negedge clk);
      seed_x = 8'h03; seed_y = 8'h05; seed_load = 1'b1; req = 1'b1;
      @(negedge clk);
      seed_load = 1'b0; req = 1'b0; reset = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (valid !== 1'b0 || busy !== 1'b0 || x_out !== 4'd0 || y_out !== 4'd0 || fallback !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_mid_search: got v=%b busy=%b x=%0d y=%0d fb=%b expected all 0",
                  valid, busy, x_out, y_out, fallback);
      end
      checks++;
      if (dut.x_reg !== 8'h03 || dut.y_reg !== 8'h0B) begin
         errors++;
         $display("[TB] FAIL reset_mid_regs: got %h/%h expected 03/0b", dut.x_reg, dut.y_reg);
      end
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_mid_after: got v=%b busy=%b expected 0/0", valid, busy);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset = 1'b1;
      req = 1'b0;
      seed_load = 1'b0;
      seed_x = 8'h00;
      seed_y = 8'h00;
      fb_req = 1'b0;
      fb_seed_load = 1'b0;
`ifdef RAND_COORD_EXCLUDE_EN
      excl_x = 4'd15;
      excl_y = 4'd15;
`endif
      $display("[TB] starting rand_coord_gen bench");
      test_reset();
      test_basic();
      test_back_to_back();
      test_fallback();
      test_zero_seed();
`ifdef RAND_COORD_EXCLUDE_EN
      test_exclusion();
`endif
      test_statistics();
      test_reset_mid_search();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
